stress_decay: RTL and testbench

STRESS_DECAY -- requirements
Module: stress_decay

---
 rtl/stress_decay.sv | 131 +++++++++++++
 tb/tb_stress_decay.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/stress_decay.sv
// Stress accumulator: absolute loads, handshake-driven calming requests and
// periodic tick-based decay, all saturating at zero.
module stress_decay #(
  parameter int DECAY_PERIOD = 100,
  parameter int DECAY_STEP   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  input  logic [7:0] load_value,
  input  logic       sub_valid,
  input  logic [7:0] sub_value,
  output logic       sub_ready,
  output logic       sub_done,
  input  logic       tick,
  output logic [7:0] stress,
  output logic       calm,
  output logic       underflow
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  localparam logic [7:0] PERIOD_LAST = 8'(DECAY_PERIOD - 1);
  localparam logic [9:0] STEP_W      = 10'(DECAY_STEP);

  // Returns {negative, clamped_result}; 10-bit difference so hold + step cannot wrap.
  function automatic logic [8:0] sat_sub(input logic [7:0] minuend, input logic [9:0] subtrahend);
    logic [9:0] diff;
    diff = {2'b00, minuend} - subtrahend;
    if (diff[9]) begin
      return {1'b1, 8'h00};
    end else begin
      return {1'b0, diff[7:0]};
    end
  endfunction

  state_t     state_r, state_nxt_s;
  logic [7:0] stress_r, stress_nxt_s;
  logic [7:0] hold_r, hold_nxt_s;
  logic [7:0] tick_cnt_r;
  logic       sub_done_r, sub_done_nxt_s;
  logic       underflow_r, underflow_nxt_s;
  logic       decay_evt_s;
  logic [9:0] sub_amt_s;
  logic [8:0] sat_s;

  assign decay_evt_s = tick && (tick_cnt_r == PERIOD_LAST);
  assign sub_amt_s   = ((state_r == APPLY) ? {2'b00, hold_r} : 10'd0)
                     + (decay_evt_s ? STEP_W : 10'd0);
  assign sat_s       = sat_sub(stress_r, sub_amt_s);

  // Tick prescaler counter; a load restarts the decay period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= 8'd0;
    end else if (load_valid) begin
      tick_cnt_r <= 8'd0;
    end else if (tick) begin
      tick_cnt_r <= (tick_cnt_r == PERIOD_LAST) ? 8'd0 : tick_cnt_r + 8'd1;
    end
  end

  // Next-state, stress update and pulse generation.
  always_comb begin
    state_nxt_s     = state_r;
    stress_nxt_s    = stress_r;
    hold_nxt_s      = hold_r;
    sub_done_nxt_s  = 1'b0;
    underflow_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_valid) begin
          stress_nxt_s = load_value;
        end else begin
          if (sub_valid) begin
            hold_nxt_s  = sub_value;
            state_nxt_s = APPLY;
          end else begin
            state_nxt_s = IDLE;
          end
          if (decay_evt_s) begin
            stress_nxt_s    = sat_s[7:0];
            underflow_nxt_s = sat_s[8];
          end else begin
            stress_nxt_s = stress_r;
          end
        end
      end
      APPLY: begin
        state_nxt_s = IDLE;
        if (load_valid) begin
          stress_nxt_s = load_value;
        end else begin
          stress_nxt_s    = sat_s[7:0];
          underflow_nxt_s = sat_s[8];
          sub_done_nxt_s  = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      stress_r    <= 8'd0;
      hold_r      <= 8'd0;
      sub_done_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      stress_r    <= stress_nxt_s;
      hold_r      <= hold_nxt_s;
      sub_done_r  <= sub_done_nxt_s;
      underflow_r <= underflow_nxt_s;
    end
  end

  assign stress    = stress_r;
  assign calm      = (stress_r == 8'd0);
  assign sub_ready = (state_r == IDLE);
  assign sub_done  = sub_done_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_stress_decay.sv
// Directed scoreboard bench for stress_decay with a 4-tick decay period and
// unit decay step.
module tb_stress_decay;

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] load_value;
  logic       sub_valid;
  logic [7:0] sub_value;
  logic       sub_ready;
  logic       sub_done;
  logic       tick;
  logic [7:0] stress;
  logic       calm;
  logic       underflow;

  typedef struct {
    string      tag;
    logic [7:0] stress;
    logic       done;
    logic       uf;
    logic       ready;
  } exp_t;

  exp_t sb_q[$];
  int   vectors;
  int   miscompares;

  stress_decay #(.DECAY_PERIOD(4), .DECAY_STEP(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_value (load_value),
    .sub_valid  (sub_valid),
    .sub_value  (sub_value),
    .sub_ready  (sub_ready),
    .sub_done   (sub_done),
    .tick       (tick),
    .stress     (stress),
    .calm       (calm),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic lv, input logic [7:0] lval, input logic sv,
                       input logic [7:0] sval, input logic tk);
    load_valid = lv;
    load_value = lval;
    sub_valid  = sv;
    sub_value  = sval;
    tick       = tk;
  endtask

  task automatic push(input string tag, input logic [7:0] s, input logic d,
                      input logic u, input logic r);
    exp_t e;
    e.tag = tag; e.stress = s; e.done = d; e.uf = u; e.ready = r;
    sb_q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    e = sb_q.pop_front();
    cmp({e.tag, ".stress"}, {1'b0, stress}, {1'b0, e.stress});
    cmp({e.tag, ".done"}, {8'd0, sub_done}, {8'd0, e.done});
    cmp({e.tag, ".underflow"}, {8'd0, underflow}, {8'd0, e.uf});
    cmp({e.tag, ".ready"}, {8'd0, sub_ready}, {8'd0, e.ready});
    cmp({e.tag, ".calm"}, {8'd0, calm}, {8'd0, (e.stress == 8'd0)});
  endtask

  // Expectation describes outputs after the next rising edge.
  task automatic step(input string tag, input logic [7:0] s, input logic d,
                      input logic u, input logic r);
    push(tag, s, d, u, r);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    #3;
    push("reset", 8'd0, 1'b0, 1'b0, 1'b1);
    check_pop();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic calming request
    drive(1'b1, 8'd200, 1'b0, 8'd0, 1'b0); step("load200", 8'd200, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 1'b1, 8'd50, 1'b0);  step("acc50", 8'd200, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);   step("apply50", 8'd150, 1'b1, 1'b0, 1'b1);
    step("after50", 8'd150, 1'b0, 1'b0, 1'b1);

    // Clamped subtraction
    drive(1'b1, 8'd30, 1'b0, 8'd0, 1'b0);  step("load30", 8'd30, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 1'b1, 8'd40, 1'b0);  step("acc40", 8'd30, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);   step("apply40", 8'd0, 1'b1, 1'b1, 1'b1);
    step("after40", 8'd0, 1'b0, 1'b0, 1'b1);

    // Periodic decay down to and past zero
    drive(1'b1, 8'd3, 1'b0, 8'd0, 1'b0);   step("load3", 8'd3, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      int s_exp;
      s_exp = 3 - (k / 4);
      if (s_exp < 0) s_exp = 0;
      drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
      step($sformatf("tick%0d", k), 8'(s_exp), 1'b0, (k == 16), 1'b1);
    end
    drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);   step("tickoff", 8'd0, 1'b0, 1'b0, 1'b1);

    // Apply coinciding with decay
    drive(1'b1, 8'd10, 1'b0, 8'd0, 1'b0);  step("load10", 8'd10, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
      step($sformatf("pre%0d", k), 8'd10, 1'b0, 1'b0, 1'b1);
    end
    drive(1'b0, 8'd0, 1'b1, 8'd5, 1'b0);   step("acc5", 8'd10, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);   step("apply5dec", 8'd4, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);   step("after5", 8'd4, 1'b0, 1'b0, 1'b1);

    // Load during APPLY drops the request and restarts the period
    drive(1'b1, 8'd20, 1'b0, 8'd0, 1'b0);  step("load20", 8'd20, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);   step("t1", 8'd20, 1'b0, 1'b0, 1'b1);
    step("t2", 8'd20, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 1'b1, 8'd7, 1'b0);   step("acc7", 8'd20, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'd99, 1'b0, 8'd0, 1'b0);  step("load99", 8'd99, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    for (int k = 1; k <= 3; k++) step($sformatf("cnt%0d", k), 8'd99, 1'b0, 1'b0, 1'b1);
    step("cnt4", 8'd98, 1'b0, 1'b0, 1'b1);

    // Load beats a simultaneous request, which is accepted next cycle
    drive(1'b1, 8'd50, 1'b1, 8'd10, 1'b0); step("loadsub", 8'd50, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 1'b1, 8'd10, 1'b0);  step("acc10", 8'd50, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);   step("apply10", 8'd40, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of APPLY
    drive(1'b1, 8'd77, 1'b0, 8'd0, 1'b0);  step("load77", 8'd77, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 1'b1, 8'd5, 1'b0);   step("acc5b", 8'd77, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    push("asyncrst", 8'd0, 1'b0, 1'b0, 1'b1);
    check_pop();
    @(posedge clk);
    #3 rst_n = 1'b1;
    step("postrst1", 8'd0, 1'b0, 1'b0, 1'b1);
    step("postrst2", 8'd0, 1'b0, 1'b0, 1'b1);

    cmp("sb_empty", 9'(sb_q.size()), 9'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
